// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regfile
//  Description : I2C target with a 7-bit address match, register-pointer byte
//                and auto-incrementing multi-byte write/read into a small
//                8-bit register file. A local fabric port loads and observes
//                the registers.
//  Options     : I2C_GLITCH_FILTER_EN - adds a 3-sample majority filter on
//                the synchronized SCL/SDA lines (2 clk extra edge latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR  = 7'h53,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              i2c_wr_pulse,
  output logic [ADDR_W-1:0] i2c_wr_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_ACK_A = 3'd2,
    S_PTR   = 3'd3,
    S_WR    = 3'd4,
    S_RD    = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_line, sda_line;
  logic       scl_prev, sda_prev;

  // Two-flop synchronizers; reset to the idle (released) bus level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  // Three-sample history feeding a majority vote; single-clk pulses lose.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end

  assign scl_line = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) |
                    (scl_hist[1] & scl_hist[2]);
  assign sda_line = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
                    (sda_hist[1] & sda_hist[2]);
`else
  assign scl_line = scl_sync[1];
  assign sda_line = sda_sync[1];
`endif

  // Previous-sample registers for edge and START/STOP detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_line;
      sda_prev <= sda_line;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_line & ~scl_prev;
  assign scl_fall  = ~scl_line & scl_prev;
  assign start_det = scl_line & scl_prev & sda_prev & ~sda_line;
  assign stop_det  = scl_line & scl_prev & ~sda_prev & sda_line;

  state_t            state;
  logic [7:0]        regs [NUM_REGS];
  logic [6:0]        shift_in;   // bits already received of the current byte
  logic [6:0]        tx;         // remaining bits of the byte being sent
  logic [3:0]        cnt;        // 0-7 data bits, 8/9 ACK slot phases
  logic              rw;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        rx_byte;

  assign rx_byte = {shift_in, sda_line};

  // Protocol FSM plus register file; I2C commits follow local writes so they win.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= S_IDLE;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      i2c_wr_pulse <= 1'b0;
      i2c_wr_addr  <= '0;
      loc_rdata    <= 8'h00;
      shift_in     <= '0;
      tx           <= '0;
      cnt          <= 4'd0;
      rw           <= 1'b0;
      ptr          <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      i2c_wr_pulse <= 1'b0;
      loc_rdata    <= regs[loc_addr];
      if (loc_we) regs[loc_addr] <= loc_wdata;

      if (start_det) begin
        state  <= S_ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_WAIT: ;
          S_ADDR: begin
            if (scl_rise) begin
              shift_in <= rx_byte[6:0];
              cnt      <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw    <= rx_byte[0];
                  state <= S_ACK_A;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          S_ACK_A: begin
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                cnt    <= 4'd9;
              end else begin
                cnt <= 4'd0;
                if (rw) begin
                  tx     <= regs[ptr][6:0];
                  sda_oe <= ~regs[ptr][7];
                  state  <= S_RD;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= S_PTR;
                end
              end
            end
          end
          S_PTR, S_WR: begin
            if (scl_rise && cnt < 4'd8) begin
              shift_in <= rx_byte[6:0];
              cnt      <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (state == S_PTR) begin
                  ptr <= rx_byte[ADDR_W-1:0];
                end else begin
                  regs[ptr]    <= rx_byte;
                  i2c_wr_pulse <= 1'b1;
                  i2c_wr_addr  <= ptr;
                  ptr          <= ptr + 1'b1;
                end
              end
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe <= 1'b1;
              cnt    <= 4'd9;
            end else if (scl_fall && cnt == 4'd9) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= S_WR;
            end
          end
          S_RD: begin
            if (scl_fall) begin
              if (cnt < 4'd7) begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
                cnt    <= cnt + 4'd1;
              end else if (cnt == 4'd7) begin
                sda_oe <= 1'b0;
                cnt    <= 4'd8;
              end else if (cnt == 4'd9) begin
                tx     <= regs[ptr][6:0];
                sda_oe <= ~regs[ptr][7];
                cnt    <= 4'd0;
              end
            end else if (scl_rise && cnt == 4'd8) begin
              if (!sda_line) begin
                ptr <= ptr + 1'b1;
                cnt <= 4'd9;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_regfile
//  Description : Directed bench for i2c_target_regfile; bit-banged I2C master
//                with wired-AND SDA and hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regfile;

  localparam int Q = 60;  // quarter SCL period in ns (SCL = 24 clk)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       loc_we = 1'b0;
  logic [3:0] loc_addr = 4'd0;
  logic [7:0] loc_wdata = 8'd0;
  logic       sda_oe, busy, i2c_wr_pulse;
  logic [3:0] i2c_wr_addr;
  logic [7:0] loc_rdata;
  logic       sda_bus;

  int passed = 0;
  int total  = 0;
  logic [3:0] wr_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regfile dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .scl_i        (scl_m),
    .sda_i        (sda_bus),
    .sda_oe       (sda_oe),
    .busy         (busy),
    .loc_we       (loc_we),
    .loc_addr     (loc_addr),
    .loc_wdata    (loc_wdata),
    .loc_rdata    (loc_rdata),
    .i2c_wr_pulse (i2c_wr_pulse),
    .i2c_wr_addr  (i2c_wr_addr)
  );

  always #5 clk = ~clk;

  // Record every I2C commit index, sampled away from the active edge.
  always @(negedge clk) if (i2c_wr_pulse === 1'b1) wr_q.push_back(i2c_wr_addr);

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); loc_addr = a;
    @(negedge clk); d = loc_rdata;
    #2;
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    @(negedge clk); loc_we = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    #22;
    total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (i2c_wr_pulse !== 1'b0) $display("FAIL reset_wr_pulse: got %b expected 0", i2c_wr_pulse); else passed++;
    total++; if (i2c_wr_addr !== 4'h0) $display("FAIL reset_wr_addr: got %h expected 0", i2c_wr_addr); else passed++;
    total++; if (loc_rdata !== 8'h00) $display("FAIL reset_loc_rdata: got %h expected 00", loc_rdata); else passed++;
    rst_n = 1'b1;
    loc_read(4'd7, d);
    total++; if (d !== 8'h00) $display("FAIL reset_reg7: got %h expected 00", d); else passed++;
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    wr_q.delete();
    i2c_start();
    write_byte(8'hA6, a0);
    write_byte(8'h02, a1);
    write_byte(8'hA5, a2);
    write_byte(8'h3C, a3);
    total++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL wr_acks: got %b expected 0000", {a0, a1, a2, a3}); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL wr_busy_active: got %b expected 1", busy); else passed++;
    i2c_stop();
    total++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b expected 0", busy); else passed++;
    total++; if (wr_q.size() != 2) $display("FAIL wr_pulse_count: got %0d expected 2", wr_q.size()); else passed++;
    total++; if (wr_q.size() < 1 || wr_q[0] !== 4'h2) $display("FAIL wr_pulse_addr0: got %h expected 2", (wr_q.size() > 0) ? wr_q[0] : 4'hx); else passed++;
    total++; if (wr_q.size() < 2 || wr_q[1] !== 4'h3) $display("FAIL wr_pulse_addr1: got %h expected 3", (wr_q.size() > 1) ? wr_q[1] : 4'hx); else passed++;
    loc_read(4'd2, d);
    total++; if (d !== 8'hA5) $display("FAIL wr_reg2: got %h expected A5", d); else passed++;
    loc_read(4'd3, d);
    total++; if (d !== 8'h3C) $display("FAIL wr_reg3: got %h expected 3C", d); else passed++;
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d;
    loc_write(4'd5, 8'h81);
    loc_write(4'd6, 8'h7E);
    wr_q.delete();
    i2c_start();
    write_byte(8'hA6, a0);
    write_byte(8'h05, a1);
    i2c_start();
    write_byte(8'hA7, a2);
    total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rd_acks: got %b expected 000", {a0, a1, a2}); else passed++;
    read_byte(d, 1'b0);
    total++; if (d !== 8'h81) $display("FAIL rd_byte0: got %h expected 81", d); else passed++;
    read_byte(d, 1'b1);
    total++; if (d !== 8'h7E) $display("FAIL rd_byte1: got %h expected 7E", d); else passed++;
    #Q;
    total++; if (sda_oe !== 1'b0) $display("FAIL rd_wait_sda_oe: got %b expected 0", sda_oe); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rd_wait_busy: got %b expected 1", busy); else passed++;
    i2c_stop();
    total++; if (busy !== 1'b0) $display("FAIL rd_busy_after_stop: got %b expected 0", busy); else passed++;
    total++; if (wr_q.size() != 0) $display("FAIL rd_no_commit: got %0d expected 0", wr_q.size()); else passed++;
  endtask

  task automatic test_nomatch();
    logic a;
    logic [7:0] d;
    wr_q.delete();
    i2c_start();
    write_byte(8'h3A, a);
    total++; if (a !== 1'b1) $display("FAIL nm_nack: got %b expected 1", a); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL nm_busy: got %b expected 0", busy); else passed++;
    i2c_stop();
    loc_read(4'd2, d);
    total++; if (d !== 8'hA5) $display("FAIL nm_reg2: got %h expected A5", d); else passed++;
    total++; if (wr_q.size() != 0) $display("FAIL nm_no_commit: got %0d expected 0", wr_q.size()); else passed++;
    i2c_start();
    write_byte(8'hA6, a);
    total++; if (a !== 1'b0) $display("FAIL nm_next_ack: got %b expected 0", a); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL nm_next_busy: got %b expected 1", busy); else passed++;
    i2c_stop();
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    wr_q.delete();
    i2c_start();
    write_byte(8'hA6, a0);
    write_byte(8'h0F, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    i2c_stop();
    total++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL wrap_acks: got %b expected 0000", {a0, a1, a2, a3}); else passed++;
    loc_read(4'd15, d);
    total++; if (d !== 8'h11) $display("FAIL wrap_reg15: got %h expected 11", d); else passed++;
    loc_read(4'd0, d);
    total++; if (d !== 8'h22) $display("FAIL wrap_reg0: got %h expected 22", d); else passed++;
    total++; if (wr_q.size() < 2 || wr_q[0] !== 4'hF || wr_q[1] !== 4'h0)
      $display("FAIL wrap_pulse_addrs: got count %0d expected F then 0", wr_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA6, a0);
    write_byte(8'h00, a1);
    i2c_start();
    write_byte(8'hA7, a2);
    #Q;
    // reg[0] holds 0x22, so its MSB (0) is being driven low right now
    total++; if (sda_oe !== 1'b1) $display("FAIL mid_sda_oe_driving: got %b expected 1", sda_oe); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (sda_oe !== 1'b0) $display("FAIL mid_async_sda_oe: got %b expected 0", sda_oe); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_async_busy: got %b expected 0", busy); else passed++;
    #20;
    rst_n = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    #Q;
    loc_read(4'd0, d);
    total++; if (d !== 8'h00) $display("FAIL mid_reg0_cleared: got %h expected 00", d); else passed++;
    wr_q.delete();
    i2c_start();
    write_byte(8'hA6, a0);
    write_byte(8'h04, a1);
    write_byte(8'h5A, a3);
    i2c_stop();
    total++; if ({a0, a1, a3} !== 3'b000) $display("FAIL mid_next_acks: got %b expected 000", {a0, a1, a3}); else passed++;
    loc_read(4'd4, d);
    total++; if (d !== 8'h5A) $display("FAIL mid_next_reg4: got %h expected 5A", d); else passed++;
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic write_bit_glitch(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #Q; scl_m = 1'b0; #10; scl_m = 1'b1; #(Q-10); scl_m = 1'b0; #Q;
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    logic [7:0] d;
    logic [7:0] v;
    v = 8'hC3;
    i2c_start();
    write_byte(8'hA6, a0);
    write_byte(8'h07, a1);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) write_bit_glitch(v[i]);
      else write_bit(v[i]);
    end
    read_bit(a2);
    i2c_stop();
    total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL glitch_acks: got %b expected 000", {a0, a1, a2}); else passed++;
    loc_read(4'd7, d);
    total++; if (d !== 8'hC3) $display("FAIL glitch_reg7: got %h expected C3", d); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_wrap();
    test_reset_mid_read();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
